med_reminder_scheduler: RTL and testbench

Periodic reader of the RAM1 medicine table. On every time-base tick it sweeps all 16 RAM1 entries, each entry `{Freq[7:4], MedID[3:0]}` stored at address `MedID`, and keeps a per-medicine elapsed-tick counter. When a medicine's counter reaches its frequency, the block raises a pending reminder and presents it on the alarm outputs until it is acknowledged. It sits on the read side of RAM1, alongside the write-side controller, and feeds the user-alarm/display logic.

---
 rtl/med_pkg.sv | 20 ++
 rtl/med_reminder_scheduler_if.sv | 39 +++
 rtl/med_prio_enc16.sv | 18 +
 rtl/med_reminder_scheduler.sv | 109 ++++++++++
 tb/tb_med_reminder_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/med_pkg.sv
// Shared constants and FSM encoding for the RAM1 medicine reminder scheduler.
package med_pkg;

   localparam int N_ENTRIES = 16;
   localparam int ID_W      = 4;
   localparam int FREQ_W    = 4;

   localparam int FREQ_MSB = 7;
   localparam int FREQ_LSB = 4;
   localparam int ID_MSB   = 3;
   localparam int ID_LSB   = 0;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      EVAL
   } state_t;

endpackage

// File: rtl/med_reminder_scheduler_if.sv
// Tick/ack inputs, RAM1 read port and alarm outputs of the reminder scheduler.
interface med_reminder_scheduler_if;
   import med_pkg::*;

   logic              Tick;
   logic [7:0]        Read_Data;
   logic              Ack;
   logic              Read_Enable;
   logic [ID_W-1:0]   Read_Address;
   logic              Busy;
   logic              Alarm;
   logic [ID_W-1:0]   Alarm_MedID;
   logic              Overrun;

   modport slave (
      input  Tick,
      input  Read_Data,
      input  Ack,
      output Read_Enable,
      output Read_Address,
      output Busy,
      output Alarm,
      output Alarm_MedID,
      output Overrun
   );

   modport master (
      output Tick,
      output Read_Data,
      output Ack,
      input  Read_Enable,
      input  Read_Address,
      input  Busy,
      input  Alarm,
      input  Alarm_MedID,
      input  Overrun
   );

endinterface

// File: rtl/med_prio_enc16.sv
// 16-bit lowest-set-bit priority encoder with an any-set flag.
module med_prio_enc16
   import med_pkg::*;
(
   input  logic [N_ENTRIES-1:0] i_vec,
   output logic                 o_any,
   output logic [ID_W-1:0]      o_idx
);

   always_comb begin
      o_any = |i_vec;
      o_idx = '0;
      for (int i = N_ENTRIES - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/med_reminder_scheduler.sv
// Sweeps RAM1 on every tick, ages each medicine and raises reminders.
module med_reminder_scheduler
   import med_pkg::*;
(
   input  logic                     Clk,
   input  logic                     Rst,
   med_reminder_scheduler_if.slave  bus
);

   localparam logic [FREQ_W:0] E_ONE = 1;

   state_t                r_state;
   state_t                w_next;
   logic                  w_start;
   logic [ID_W-1:0]       r_idx;
   logic                  r_tick_q;
   logic                  r_overrun;
   logic [N_ENTRIES-1:0]  r_pending;
   logic [FREQ_W-1:0]     r_elapsed [N_ENTRIES];
   logic                  r_alarm;
   logic [ID_W-1:0]       r_alarm_id;

   logic                  w_any;
   logic [ID_W-1:0]       w_enc_id;
   logic [FREQ_W-1:0]     w_freq;
   logic [ID_W-1:0]       w_id;
   logic                  w_valid;
   logic [FREQ_W:0]       w_e;
   logic                  w_hit;
   logic [N_ENTRIES-1:0]  w_set;
   logic [N_ENTRIES-1:0]  w_clr;

   always_ff @(posedge Clk) begin
      if (!Rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.Tick || r_tick_q) begin
               w_next  = ISSUE;
               w_start = 1'b1;
            end
         end
         ISSUE:   w_next = WAIT;
         WAIT:    w_next = EVAL;
         EVAL:    w_next = (r_idx == ID_W'(N_ENTRIES - 1)) ? IDLE : ISSUE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_freq  = bus.Read_Data[FREQ_MSB:FREQ_LSB];
      w_id    = bus.Read_Data[ID_MSB:ID_LSB];
      w_valid = (w_freq != '0) && (w_id == r_idx);
      w_e     = {1'b0, r_elapsed[r_idx]} + E_ONE;
      w_hit   = w_valid && (w_e >= {1'b0, w_freq});
      w_set   = '0;
      w_clr   = '0;
      if (r_state == EVAL && w_hit) w_set[r_idx] = 1'b1;
      if (bus.Ack && r_alarm)      w_clr[r_alarm_id] = 1'b1;
   end

   // A set from EVAL overrides an ack clear of the same bit.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_idx      <= '0;
         r_tick_q   <= 1'b0;
         r_overrun  <= 1'b0;
         r_pending  <= '0;
         r_alarm    <= 1'b0;
         r_alarm_id <= '0;
         for (int i = 0; i < N_ENTRIES; i++) r_elapsed[i] <= '0;
      end else begin
         r_pending  <= (r_pending & ~w_clr) | w_set;
         r_alarm    <= w_any;
         r_alarm_id <= w_enc_id;
         if (w_start) begin
            r_idx    <= '0;
            r_tick_q <= r_tick_q & bus.Tick;
         end else if (r_state != IDLE && bus.Tick) begin
            if (r_tick_q) r_overrun <= 1'b1;
            else          r_tick_q  <= 1'b1;
         end
         if (r_state == EVAL) begin
            if (!w_valid || w_hit) r_elapsed[r_idx] <= '0;
            else                   r_elapsed[r_idx] <= w_e[FREQ_W-1:0];
            r_idx <= r_idx + ID_W'(1);
         end
      end
   end

   med_prio_enc16 u_enc (
      .i_vec (r_pending),
      .o_any (w_any),
      .o_idx (w_enc_id)
   );

   assign bus.Read_Enable  = (r_state != IDLE);
   assign bus.Busy         = (r_state != IDLE);
   assign bus.Read_Address = r_idx;
   assign bus.Alarm        = r_alarm;
   assign bus.Alarm_MedID  = r_alarm_id;
   assign bus.Overrun      = r_overrun;

endmodule

// File: tb/tb_med_reminder_scheduler.sv
// Scoreboard bench for med_reminder_scheduler with a two-stage RAM1 model.
module tb_med_reminder_scheduler;

   typedef struct {
      int         due;
      logic       alarm;
      logic [3:0] id;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;
   logic [7:0] ram [16];
   logic [7:0] rd1;

   med_reminder_scheduler_if bus ();

   med_reminder_scheduler dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(posedge Clk) begin
      rd1           <= ram[bus.Read_Address];
      bus.Read_Data <= rd1;
   end

   always @(negedge Clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (e.due < cyc) begin
            errors++;
            $display("FAIL sb_missed: due %0d seen at %0d", e.due, cyc);
         end else if (bus.Alarm !== e.alarm ||
                      (e.alarm && bus.Alarm_MedID !== e.id)) begin
            errors++;
            $display("FAIL sb_alarm cyc=%0d: got Alarm=%b id=%0d want Alarm=%b id=%0d",
                     cyc, bus.Alarm, bus.Alarm_MedID, e.alarm, e.id);
         end
      end
   end

   task automatic go(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic go_to(input int c);
      while (cyc < c) go(1);
   endtask

   task automatic push(input int due, input logic a, input logic [3:0] id);
      exp_t x;
      x.due = due;
      x.alarm = a;
      x.id = id;
      sb.push_back(x);
   endtask

   task automatic pulse_tick(output int t);
      t = cyc;
      bus.Tick = 1'b1;
      go(1);
      bus.Tick = 1'b0;
   endtask

   task automatic pulse_ack;
      bus.Ack = 1'b1;
      go(1);
      bus.Ack = 1'b0;
   endtask

   task automatic clear_ram;
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
   endtask

   task automatic do_reset;
      bus.Tick = 1'b0;
      bus.Ack  = 1'b0;
      Rst = 1'b0;
      go(2);
      Rst = 1'b1;
      go(1);
   endtask

   task automatic test_reset;
      clear_ram();
      Rst = 1'b0;
      bus.Ack = 1'b0;
      bus.Tick = 1'b1;
      go(3);
      checks++;
      if (bus.Read_Enable !== 1'b0) begin
         errors++; $display("FAIL reset_re: got %b want 0", bus.Read_Enable);
      end
      checks++;
      if (bus.Read_Address !== 4'd0) begin
         errors++; $display("FAIL reset_addr: got %0d want 0", bus.Read_Address);
      end
      checks++;
      if (bus.Busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy);
      end
      checks++;
      if (bus.Alarm !== 1'b0 || bus.Alarm_MedID !== 4'd0) begin
         errors++; $display("FAIL reset_alarm: got %b/%0d want 0/0", bus.Alarm, bus.Alarm_MedID);
      end
      checks++;
      if (bus.Overrun !== 1'b0) begin
         errors++; $display("FAIL reset_ovr: got %b want 0", bus.Overrun);
      end
      bus.Tick = 1'b0;
      Rst = 1'b1;
      go(1);
   endtask

   task automatic test_freq1;
      int t, a;
      clear_ram();
      ram[3] = 8'h13;
      do_reset();
      pulse_tick(t);
      checks++;
      if (bus.Busy !== 1'b1 || bus.Read_Enable !== 1'b1 || bus.Read_Address !== 4'd0) begin
         errors++;
         $display("FAIL f1_issue: got busy=%b re=%b addr=%0d want 1 1 0",
                  bus.Busy, bus.Read_Enable, bus.Read_Address);
      end
      push(t + 13, 1'b0, 4'd0);
      push(t + 14, 1'b1, 4'd3);
      go_to(t + 48);
      checks++;
      if (bus.Busy !== 1'b1) begin
         errors++; $display("FAIL f1_busy_last: got %b want 1", bus.Busy);
      end
      go(1);
      checks++;
      if (bus.Busy !== 1'b0 || bus.Read_Enable !== 1'b0) begin
         errors++; $display("FAIL f1_idle: got busy=%b re=%b want 0 0", bus.Busy, bus.Read_Enable);
      end
      go_to(t + 52);
      a = cyc;
      push(a + 1, 1'b1, 4'd3);
      push(a + 2, 1'b0, 4'd0);
      pulse_ack();
      go(3);
   endtask

   task automatic test_freq3_ghost;
      int t1, t2, t3, a;
      clear_ram();
      ram[5] = 8'h35;
      ram[6] = 8'h37;
      do_reset();
      pulse_tick(t1);
      push(t1 + 50, 1'b0, 4'd0);
      go_to(t1 + 60);
      pulse_tick(t2);
      push(t2 + 50, 1'b0, 4'd0);
      go_to(t2 + 60);
      pulse_tick(t3);
      push(t3 + 19, 1'b0, 4'd0);
      push(t3 + 20, 1'b1, 4'd5);
      go_to(t3 + 50);
      a = cyc;
      push(a + 1, 1'b1, 4'd5);
      push(a + 2, 1'b0, 4'd0);
      pulse_ack();
      go_to(a + 5);
   endtask

   task automatic test_priority;
      int t, a, b;
      clear_ram();
      ram[2] = 8'h12;
      ram[9] = 8'h19;
      do_reset();
      pulse_tick(t);
      push(t + 10, 1'b0, 4'd0);
      push(t + 11, 1'b1, 4'd2);
      push(t + 50, 1'b1, 4'd2);
      go_to(t + 50);
      a = cyc;
      push(a + 1, 1'b1, 4'd2);
      push(a + 2, 1'b1, 4'd9);
      pulse_ack();
      go_to(a + 3);
      b = cyc;
      push(b + 2, 1'b0, 4'd0);
      pulse_ack();
      go_to(b + 4);
   endtask

   task automatic test_overrun;
      int t;
      clear_ram();
      do_reset();
      pulse_tick(t);
      go_to(t + 10);
      bus.Tick = 1'b1;
      go(1);
      bus.Tick = 1'b0;
      checks++;
      if (bus.Overrun !== 1'b0) begin
         errors++; $display("FAIL ovr_early: got %b want 0", bus.Overrun);
      end
      go_to(t + 20);
      bus.Tick = 1'b1;
      go(1);
      bus.Tick = 1'b0;
      checks++;
      if (bus.Overrun !== 1'b1) begin
         errors++; $display("FAIL ovr_set: got %b want 1", bus.Overrun);
      end
      go_to(t + 49);
      checks++;
      if (bus.Busy !== 1'b0) begin
         errors++; $display("FAIL ovr_idle: got busy=%b want 0", bus.Busy);
      end
      go(1);
      checks++;
      if (bus.Busy !== 1'b1 || bus.Read_Address !== 4'd0) begin
         errors++; $display("FAIL ovr_resweep: got busy=%b addr=%0d want 1 0", bus.Busy, bus.Read_Address);
      end
      go_to(t + 120);
      checks++;
      if (bus.Overrun !== 1'b1) begin
         errors++; $display("FAIL ovr_sticky: got %b want 1", bus.Overrun);
      end
   endtask

   task automatic test_back_to_back;
      int t, u;
      clear_ram();
      do_reset();
      pulse_tick(t);
      go_to(t + 10);
      pulse_tick(u);
      go_to(t + 49);
      pulse_tick(u);
      checks++;
      if (bus.Busy !== 1'b1 || bus.Read_Address !== 4'd0) begin
         errors++; $display("FAIL b2b_second: got busy=%b addr=%0d want 1 0", bus.Busy, bus.Read_Address);
      end
      go_to(t + 98);
      checks++;
      if (bus.Busy !== 1'b0 || bus.Overrun !== 1'b0) begin
         errors++; $display("FAIL b2b_gap: got busy=%b ovr=%b want 0 0", bus.Busy, bus.Overrun);
      end
      go(1);
      checks++;
      if (bus.Busy !== 1'b1) begin
         errors++; $display("FAIL b2b_third: got busy=%b want 1", bus.Busy);
      end
      go_to(t + 148);
      checks++;
      if (bus.Busy !== 1'b0 || bus.Overrun !== 1'b0) begin
         errors++; $display("FAIL b2b_end: got busy=%b ovr=%b want 0 0", bus.Busy, bus.Overrun);
      end
   endtask

   task automatic test_ack_ignored;
      int t;
      clear_ram();
      ram[0] = 8'h10;
      do_reset();
      pulse_tick(t);
      push(t + 4, 1'b0, 4'd0);
      push(t + 5, 1'b1, 4'd0);
      push(t + 6, 1'b1, 4'd0);
      go_to(t + 4);
      pulse_ack();
      go_to(t + 50);
   endtask

   task automatic test_ack_set;
      int t, t2, a;
      clear_ram();
      ram[4] = 8'h14;
      do_reset();
      pulse_tick(t);
      push(t + 16, 1'b0, 4'd0);
      push(t + 17, 1'b1, 4'd4);
      go_to(t + 60);
      pulse_tick(t2);
      go_to(t2 + 15);
      push(t2 + 16, 1'b1, 4'd4);
      push(t2 + 17, 1'b1, 4'd4);
      push(t2 + 18, 1'b1, 4'd4);
      pulse_ack();
      go_to(t2 + 25);
      a = cyc;
      push(a + 1, 1'b1, 4'd4);
      push(a + 2, 1'b0, 4'd0);
      pulse_ack();
      go_to(a + 30);
   endtask

   task automatic test_reset_mid;
      int t, t2, t3;
      clear_ram();
      ram[0] = 8'h10;
      ram[1] = 8'h21;
      do_reset();
      pulse_tick(t);
      push(t + 5, 1'b1, 4'd0);
      go_to(t + 20);
      checks++;
      if (bus.Busy !== 1'b1 || bus.Read_Address !== 4'd6) begin
         errors++; $display("FAIL mid_pre: got busy=%b addr=%0d want 1 6", bus.Busy, bus.Read_Address);
      end
      Rst = 1'b0;
      go(1);
      Rst = 1'b1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Read_Enable !== 1'b0 || bus.Read_Address !== 4'd0 ||
          bus.Alarm !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b re=%b addr=%0d alarm=%b want 0 0 0 0",
                  bus.Busy, bus.Read_Enable, bus.Read_Address, bus.Alarm);
      end
      ram[0] = 8'h00;
      go_to(t + 30);
      pulse_tick(t2);
      checks++;
      if (bus.Read_Address !== 4'd0) begin
         errors++; $display("FAIL mid_restart0: got addr=%0d want 0", bus.Read_Address);
      end
      go_to(t2 + 4);
      checks++;
      if (bus.Read_Address !== 4'd1 || bus.Busy !== 1'b1) begin
         errors++; $display("FAIL mid_restart1: got addr=%0d busy=%b want 1 1", bus.Read_Address, bus.Busy);
      end
      push(t2 + 50, 1'b0, 4'd0);
      go_to(t2 + 60);
      pulse_tick(t3);
      push(t3 + 7, 1'b0, 4'd0);
      push(t3 + 8, 1'b1, 4'd1);
      go_to(t3 + 50);
   endtask

   initial begin
      Rst = 1'b0;
      bus.Tick = 1'b0;
      bus.Ack = 1'b0;
      clear_ram();
      test_reset();
      test_freq1();
      test_freq3_ghost();
      test_priority();
      test_overrun();
      test_back_to_back();
      test_ack_ignored();
      test_ack_set();
      test_reset_mid();
      go(2);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
